// File: rtl/nbr_expand.sv
// A* neighbour-expansion stage: for the popped node, walk the 4 (or 8) grid
// neighbours, skip out-of-bounds and walled cells, and stream survivors with
// G' = G+1 and F = G'+H to the sort block over valid/ready.
// Optional feature macro: ASTAR_DIAG_EN (8-connected, Chebyshev heuristic).
module nbr_expand #(
   parameter int COORD_W = 4,
   parameter int GRID_W  = 16,
   parameter int GRID_H  = 16,
   parameter int COST_W  = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [COORD_W-1:0]     cur_x,
   input  logic [COORD_W-1:0]     cur_y,
   input  logic [COST_W-1:0]      cur_g,
   input  logic [COORD_W-1:0]     goal_x,
   input  logic [COORD_W-1:0]     goal_y,
   output logic                   wall_rd,
   output logic [2*COORD_W-1:0]   wall_addr,
   input  logic                   wall_data,
   output logic                   nb_valid,
   input  logic                   nb_ready,
   output logic [COORD_W-1:0]     nb_x,
   output logic [COORD_W-1:0]     nb_y,
   output logic [COST_W-1:0]      nb_g,
   output logic [COST_W-1:0]      nb_f,
   output logic [2:0]             nb_dir,
   output logic                   nb_goal,
   output logic                   busy,
   output logic                   done,
   output logic [3:0]             nb_count
);

`ifdef ASTAR_DIAG_EN
   localparam logic [2:0] LAST_DIR = 3'd7;
`else
   localparam logic [2:0] LAST_DIR = 3'd3;
`endif

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WAIT, S_EMIT, S_NEXT, S_DONE} state_t;

   typedef struct packed {
      logic               oob;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } nbr_t;

   // Neighbour coordinate of (x,y) in direction d, plus an out-of-bounds flag.
   function automatic nbr_t step(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                                 input logic [2:0] d);
      nbr_t r;
      logic up, dn, lf, rt;
      up = 1'b0; dn = 1'b0; lf = 1'b0; rt = 1'b0;
      case (d)
         3'd0: up = 1'b1;
         3'd1: rt = 1'b1;
         3'd2: dn = 1'b1;
         3'd3: lf = 1'b1;
`ifdef ASTAR_DIAG_EN
         3'd4: begin up = 1'b1; rt = 1'b1; end
         3'd5: begin dn = 1'b1; rt = 1'b1; end
         3'd6: begin dn = 1'b1; lf = 1'b1; end
         3'd7: begin up = 1'b1; lf = 1'b1; end
`endif
         default: ;
      endcase
      r.oob = (up && y == '0) || (dn && y == COORD_W'(GRID_H-1)) ||
              (lf && x == '0) || (rt && x == COORD_W'(GRID_W-1));
      r.x = rt ? x + COORD_W'(1) : (lf ? x - COORD_W'(1) : x);
      r.y = dn ? y + COORD_W'(1) : (up ? y - COORD_W'(1) : y);
      return r;
   endfunction

   function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
      return (a >= b) ? a - b : b - a;
   endfunction

   state_t               state;
   logic [2:0]           dir;
   logic [COORD_W-1:0]   lat_x, lat_y, lat_gx, lat_gy;
   logic [COST_W-1:0]    lat_g;

   nbr_t                 cur_n, next_n, start_n;
   logic [COST_W-1:0]    dx, dy, h, g_next, f_sat;
   logic [COST_W:0]      f_sum;

   // Neighbour geometry and cost arithmetic for the current, next and first direction.
   always_comb begin
      cur_n   = step(lat_x, lat_y, dir);
      next_n  = step(lat_x, lat_y, dir + 3'd1);
      start_n = step(cur_x, cur_y, 3'd0);
      dx      = COST_W'(abs_diff(cur_n.x, lat_gx));
      dy      = COST_W'(abs_diff(cur_n.y, lat_gy));
`ifdef ASTAR_DIAG_EN
      h       = (dx > dy) ? dx : dy;
`else
      h       = dx + dy;
`endif
      g_next  = (lat_g == '1) ? lat_g : lat_g + COST_W'(1);
      f_sum   = {1'b0, g_next} + {1'b0, h};
      f_sat   = f_sum[COST_W] ? '1 : f_sum[COST_W-1:0];
   end

   // Expansion FSM; every output is a register updated on state transitions.
   // NOTE: sequential state uses <= so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         dir       <= '0;
         lat_x     <= '0;
         lat_y     <= '0;
         lat_gx    <= '0;
         lat_gy    <= '0;
         lat_g     <= '0;
         wall_rd   <= 1'b0;
         wall_addr <= '0;
         nb_valid  <= 1'b0;
         nb_x      <= '0;
         nb_y      <= '0;
         nb_g      <= '0;
         nb_f      <= '0;
         nb_dir    <= '0;
         nb_goal   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         nb_count  <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               lat_x    <= cur_x;
               lat_y    <= cur_y;
               lat_g    <= cur_g;
               lat_gx   <= goal_x;
               lat_gy   <= goal_y;
               dir      <= '0;
               nb_count <= '0;
               busy     <= 1'b1;
               wall_rd  <= !start_n.oob;
               if (!start_n.oob) wall_addr <= {start_n.y, start_n.x};
               state    <= S_CHECK;
            end
            S_CHECK: begin
               wall_rd <= 1'b0;
               state   <= cur_n.oob ? S_NEXT : S_WAIT;
            end
            S_WAIT: if (wall_data) begin
               state <= S_NEXT;
            end else begin
               nb_x     <= cur_n.x;
               nb_y     <= cur_n.y;
               nb_g     <= g_next;
               nb_f     <= f_sat;
`ifdef ASTAR_DIAG_EN
               nb_dir   <= dir;
`else
               nb_dir   <= {1'b0, dir[1:0]};
`endif
               nb_goal  <= (cur_n.x == lat_gx) && (cur_n.y == lat_gy);
               nb_valid <= 1'b1;
               state    <= S_EMIT;
            end
            S_EMIT: if (nb_ready) begin
               nb_valid <= 1'b0;
               nb_count <= nb_count + 4'd1;
               state    <= S_NEXT;
            end
            S_NEXT: if (dir == LAST_DIR) begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_DONE;
            end else begin
               dir     <= dir + 3'd1;
               wall_rd <= !next_n.oob;
               if (!next_n.oob) wall_addr <= {next_n.y, next_n.x};
               state   <= S_CHECK;
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nbr_expand.sv
// Directed testbench for nbr_expand (default 4-connected build).
module tb_nbr_expand;

   logic       clk, rst_n, start;
   logic [3:0] cur_x, cur_y, goal_x, goal_y;
   logic [7:0] cur_g;
   logic       wall_rd, wall_data;
   logic [7:0] wall_addr;
   logic       nb_valid, nb_ready;
   logic [3:0] nb_x, nb_y;
   logic [7:0] nb_g, nb_f;
   logic [2:0] nb_dir;
   logic       nb_goal, busy, done;
   logic [3:0] nb_count;

   nbr_expand dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cur_x(cur_x), .cur_y(cur_y), .cur_g(cur_g), .goal_x(goal_x), .goal_y(goal_y),
      .wall_rd(wall_rd), .wall_addr(wall_addr), .wall_data(wall_data),
      .nb_valid(nb_valid), .nb_ready(nb_ready), .nb_x(nb_x), .nb_y(nb_y),
      .nb_g(nb_g), .nb_f(nb_f), .nb_dir(nb_dir), .nb_goal(nb_goal),
      .busy(busy), .done(done), .nb_count(nb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Wall map: answers a read strobe on the following cycle.
   logic [255:0] wall_map;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) wall_data <= 1'b0;
      else        wall_data <= wall_rd && wall_map[wall_addr];

   int n_checks = 0;
   int n_fail   = 0;

   // Results collected by expand().
   logic [27:0] beats [8];
   logic [7:0]  rd_addr [8];
   int          n_beats, n_rd, first_rd, first_vld, dup, stall_seen, stall_bad;
   bit          done_seen;
   logic [3:0]  done_cnt;

   function automatic logic [27:0] pk(input logic [3:0] x, input logic [3:0] y,
                                      input logic [7:0] g, input logic [7:0] f,
                                      input logic [2:0] d, input logic gl);
      return {gl, d, x, y, g, f};
   endfunction

   function automatic logic [27:0] dut_beat();
      return pk(nb_x, nb_y, nb_g, nb_f, nb_dir, nb_goal);
   endfunction

   // Runs one expansion, optionally stalling the beat of stall_dir for stall_n cycles.
   task automatic expand(input logic [3:0] x, input logic [3:0] y, input logic [7:0] g,
                         input logic [3:0] gx, input logic [3:0] gy,
                         input int stall_dir, input int stall_n, input bit poke);
      int stall_left;
      bit prev_acc;
      logic [27:0] held;
      n_beats = 0; n_rd = 0; first_rd = -1; first_vld = -1; dup = 0;
      stall_seen = 0; stall_bad = 0; done_seen = 0; done_cnt = '0;
      stall_left = stall_n; prev_acc = 0; held = '0;
      @(negedge clk);
      cur_x = x; cur_y = y; cur_g = g; goal_x = gx; goal_y = gy;
      start = 1'b1; nb_ready = 1'b1;
      @(negedge clk);
      for (int cyc = 1; cyc < 200 && !done_seen; cyc++) begin
         start = 1'b0;
         if (wall_rd) begin
            if (first_rd < 0) first_rd = cyc;
            if (n_rd < 8) rd_addr[n_rd] = wall_addr;
            n_rd++;
         end
         if (prev_acc && nb_valid) dup++;
         prev_acc = 0;
         if (nb_valid) begin
            if (first_vld < 0) first_vld = cyc;
            if (int'(nb_dir) == stall_dir && stall_left > 0) begin
               if (stall_left == stall_n) begin
                  held = dut_beat();
                  if (poke) begin
                     start = 1'b1; cur_x = 4'd0; cur_y = 4'd0; cur_g = 8'd100;
                  end
               end else if (dut_beat() !== held) stall_bad++;
               stall_seen++;
               stall_left--;
               nb_ready = 1'b0;
            end else begin
               if (n_beats < 8) beats[n_beats] = dut_beat();
               n_beats++;
               nb_ready = 1'b1;
               prev_acc = 1;
            end
         end else begin
            nb_ready = 1'b1;
         end
         if (done) begin
            done_seen = 1;
            done_cnt  = nb_count;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; nb_ready = 1'b0; wall_map = '0;
      cur_x = '0; cur_y = '0; cur_g = '0; goal_x = '0; goal_y = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({wall_rd, wall_addr, nb_valid, busy, done, nb_count} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %h want 0", {wall_rd, wall_addr, nb_valid, busy, done, nb_count});
      end
      n_checks++;
      if (dut_beat() !== 28'h0) begin
         n_fail++;
         $display("FAIL reset_fields: got %h want 0", dut_beat());
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [27:0] exp_b [4];
      exp_b[0] = pk(4'd5, 4'd4, 8'd4, 8'd9, 3'd0, 1'b0);
      exp_b[1] = pk(4'd6, 4'd5, 8'd4, 8'd7, 3'd1, 1'b0);
      exp_b[2] = pk(4'd5, 4'd6, 8'd4, 8'd9, 3'd2, 1'b0);
      exp_b[3] = pk(4'd4, 4'd5, 8'd4, 8'd9, 3'd3, 1'b0);
      expand(4'd5, 4'd5, 8'd3, 4'd9, 4'd5, -1, 0, 0);
      n_checks++;
      if (!done_seen || done_cnt !== 4'd4 || n_beats != 4) begin
         n_fail++;
         $display("FAIL basic_count: done=%0d nb_count=%0d beats=%0d want 1/4/4", done_seen, done_cnt, n_beats);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (beats[i] !== exp_b[i]) begin
            n_fail++;
            $display("FAIL basic_beat%0d: got %h want %h", i, beats[i], exp_b[i]);
         end
      end
      n_checks++;
      if (first_rd != 1 || first_vld != 3 || n_rd != 4) begin
         n_fail++;
         $display("FAIL basic_latency: wall_rd@%0d valid@%0d reads=%0d want 1/3/4", first_rd, first_vld, n_rd);
      end
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || nb_count !== 4'd4) begin
         n_fail++;
         $display("FAIL basic_after: done=%0d busy=%0d nb_count=%0d want 0/0/4", done, busy, nb_count);
      end
   endtask

   task automatic test_corner();
      expand(4'd0, 4'd0, 8'd0, 4'd9, 4'd5, -1, 0, 0);
      n_checks++;
      if (done_cnt !== 4'd2 || n_rd != 2 || rd_addr[0] !== 8'h01 || rd_addr[1] !== 8'h10) begin
         n_fail++;
         $display("FAIL corner_reads: count=%0d reads=%0d addr=%h,%h want 2/2/01,10", done_cnt, n_rd, rd_addr[0], rd_addr[1]);
      end
      n_checks++;
      if (beats[0] !== pk(4'd1, 4'd0, 8'd1, 8'd14, 3'd1, 1'b0) ||
          beats[1] !== pk(4'd0, 4'd1, 8'd1, 8'd14, 3'd2, 1'b0)) begin
         n_fail++;
         $display("FAIL corner_beats: got %h %h", beats[0], beats[1]);
      end
   endtask

   task automatic test_goal();
      expand(4'd15, 4'd15, 8'd0, 4'd14, 4'd15, -1, 0, 0);
      n_checks++;
      if (done_cnt !== 4'd2 || n_rd != 2 ||
          beats[0] !== pk(4'd15, 4'd14, 8'd1, 8'd3, 3'd0, 1'b0) ||
          beats[1] !== pk(4'd14, 4'd15, 8'd1, 8'd1, 3'd3, 1'b1)) begin
         n_fail++;
         $display("FAIL goal_beats: count=%0d reads=%0d got %h %h", done_cnt, n_rd, beats[0], beats[1]);
      end
   endtask

   task automatic test_wall();
      wall_map = '0;
      wall_map[8'h56] = 1'b1;
      expand(4'd5, 4'd5, 8'd3, 4'd9, 4'd5, -1, 0, 0);
      n_checks++;
      if (done_cnt !== 4'd3 || n_rd != 4 || rd_addr[1] !== 8'h56) begin
         n_fail++;
         $display("FAIL wall_count: count=%0d reads=%0d addr1=%h want 3/4/56", done_cnt, n_rd, rd_addr[1]);
      end
      n_checks++;
      if (beats[0] !== pk(4'd5, 4'd4, 8'd4, 8'd9, 3'd0, 1'b0) ||
          beats[1] !== pk(4'd5, 4'd6, 8'd4, 8'd9, 3'd2, 1'b0) ||
          beats[2] !== pk(4'd4, 4'd5, 8'd4, 8'd9, 3'd3, 1'b0)) begin
         n_fail++;
         $display("FAIL wall_beats: got %h %h %h", beats[0], beats[1], beats[2]);
      end
      wall_map[8'h45] = 1'b1; wall_map[8'h65] = 1'b1; wall_map[8'h54] = 1'b1;
      expand(4'd5, 4'd5, 8'd3, 4'd9, 4'd5, -1, 0, 0);
      n_checks++;
      if (!done_seen || done_cnt !== 4'd0 || n_beats != 0) begin
         n_fail++;
         $display("FAIL zero_survivors: done=%0d count=%0d beats=%0d want 1/0/0", done_seen, done_cnt, n_beats);
      end
      wall_map = '0;
   endtask

   task automatic test_back_to_back_stall();
      expand(4'd5, 4'd5, 8'd3, 4'd9, 4'd5, 1, 5, 1);
      n_checks++;
      if (stall_seen != 5 || stall_bad != 0 || dup != 0) begin
         n_fail++;
         $display("FAIL stall_hold: stalls=%0d unstable=%0d dups=%0d want 5/0/0", stall_seen, stall_bad, dup);
      end
      n_checks++;
      if (done_cnt !== 4'd4 || n_beats != 4 || beats[1] !== pk(4'd6, 4'd5, 8'd4, 8'd7, 3'd1, 1'b0) ||
          beats[3] !== pk(4'd4, 4'd5, 8'd4, 8'd9, 3'd3, 1'b0)) begin
         n_fail++;
         $display("FAIL stall_beats: count=%0d beats=%0d E=%h W=%h", done_cnt, n_beats, beats[1], beats[3]);
      end
   endtask

   task automatic test_saturate();
      expand(4'd5, 4'd5, 8'd255, 4'd9, 4'd5, -1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (beats[i][15:0] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat255_beat%0d: g/f got %h want ffff", i, beats[i][15:0]);
         end
      end
      expand(4'd5, 4'd5, 8'd250, 4'd9, 4'd5, -1, 0, 0);
      n_checks++;
      if (beats[0][15:0] !== {8'd251, 8'd255} || beats[1][15:0] !== {8'd251, 8'd254}) begin
         n_fail++;
         $display("FAIL sat250: N=%h E=%h want fbff fbfe", beats[0][15:0], beats[1][15:0]);
      end
   endtask

   task automatic test_reset_mid();
      bit got_valid;
      got_valid = 0;
      @(negedge clk);
      cur_x = 4'd5; cur_y = 4'd5; cur_g = 8'd3; goal_x = 4'd9; goal_y = 4'd5;
      start = 1'b1; nb_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10 && !got_valid; i++) begin
         if (nb_valid) got_valid = 1;
         else @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (!got_valid || nb_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: reached_emit=%0d valid=%0d busy=%0d done=%0d want 1/0/0/0", got_valid, nb_valid, busy, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      nb_ready = 1'b1;
      expand(4'd5, 4'd5, 8'd3, 4'd9, 4'd5, -1, 0, 0);
      n_checks++;
      if (!done_seen || done_cnt !== 4'd4 || beats[1] !== pk(4'd6, 4'd5, 8'd4, 8'd7, 3'd1, 1'b0)) begin
         n_fail++;
         $display("FAIL reset_restart: done=%0d count=%0d E=%h", done_seen, done_cnt, beats[1]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corner();
      test_goal();
      test_wall();
      test_back_to_back_stall();
      test_saturate();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nbr_expand.md
Name: nbr_expand

Overview:
- Neighbour-expansion stage that sits directly upstream of the sort/open-list block in the A* search datapath.
- For the node currently popped from the open list, it generates up to 4 grid neighbours.
- It drops neighbours that are out of bounds or walled, and computes G' = G+1, H (Manhattan distance to goal) and F = G'+H.
- Surviving neighbours stream into sort one per valid/ready handshake.

Parameters:
- COORD_W, 4, bits per X/Y coordinate.
- GRID_W, 16, grid columns; legal X is 0..GRID_W-1.
- GRID_H, 16, grid rows; legal Y is 0..GRID_H-1.
- COST_W, 8, width of G/H/F cost fields.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  1-cycle request to expand the current node; ignored while Busy=1.
- Cur_X  in  COORD_W  current node X; latched on accepted Start.
- Cur_Y  in  COORD_W  current node Y; latched on accepted Start.
- Cur_G  in  COST_W  current node cost-so-far; latched on accepted Start.
- Goal_X  in  COORD_W  goal X; latched on accepted Start.
- Goal_Y  in  COORD_W  goal Y; latched on accepted Start.
- Wall_Rd  out  1  wall-map read strobe.
- Wall_Addr  out  2*COORD_W  wall-map address {Y,X}.
- Wall_Data  in  1  1 = blocked; valid the cycle after Wall_Rd.
- Nb_Valid  out  1  neighbour beat valid.
- Nb_Ready  in  1  sort accepts the beat.
- Nb_X  out  COORD_W  neighbour X.
- Nb_Y  out  COORD_W  neighbour Y.
- Nb_G  out  COST_W  neighbour G'.
- Nb_F  out  COST_W  neighbour F.
- Nb_Dir  out  3  direction index from parent (parent pointer).
- Nb_Goal  out  1  neighbour equals goal.
- Busy  out  1  expansion in progress.
- Done  out  1  1-cycle pulse when all directions are processed.
- Nb_Count  out  4  beats emitted in the last expansion; held until the next Start.

Behaviour:
Reset (async, Reset=0):
- FSM goes to IDLE.
- All outputs are 0 and the direction counter is 0.
- Reset mid-operation aborts immediately: Nb_Valid drops with no handshake.

Direction order:
- 0 N (Y-1), 1 E (X+1), 2 S (Y+1), 3 W (X-1).
- Nb_Dir[2] = 0 unless the optional feature is enabled.

FSM:
- IDLE:
  - Start=1 latches the inputs, clears Nb_Count and the direction counter, sets Busy=1, and goes to CHECK.
- CHECK:
  - If the neighbour is out of bounds, no Wall_Rd is issued; go to NEXT.
  - Out of bounds means X-1 at X=0, X+1 at X=GRID_W-1, and likewise for Y.
  - Otherwise assert Wall_Rd for one cycle with Wall_Addr={nY,nX} and go to WAIT.
- WAIT:
  - Sample Wall_Data.
  - If 1, go to NEXT.
  - If 0, register Nb_X/Nb_Y/Nb_G/Nb_F/Nb_Dir/Nb_Goal and go to EMIT.
- EMIT:
  - Nb_Valid=1; all Nb_* fields are held stable.
  - On Nb_Valid&&Nb_Ready: Nb_Count++ and go to NEXT.
  - Nb_Valid deasserts the following cycle.
- NEXT:
  - If the last direction is done, go to DONE.
  - Otherwise increment the direction and go to CHECK.
- DONE:
  - Done=1 for one cycle, Busy=0, go to IDLE.

Minimum latency:
- Start at cycle 0 -> Wall_Rd at cycle 1 -> first Nb_Valid at cycle 3.

Arithmetic:
- G' = Cur_G+1, saturating at 2^COST_W-1.
- H = |nX-Goal_X| + |nY-Goal_Y|, computed in COST_W bits.
- F = G'+H, saturating at 2^COST_W-1.
- Nb_Goal = (nX==Goal_X && nY==Goal_Y), in which case H=0.

Boundary cases:
- Start in any state other than IDLE is ignored.
- Expansion with zero survivors still produces a Done pulse, with Nb_Count=0.
- Nb_Ready high outside EMIT has no effect.

Optional Feature:
ASTAR_DIAG_EN:
- When defined, expansion is 8-connected.
- Directions 4 NE, 5 SE, 6 SW, 7 NW are appended after W.
- A diagonal is out of bounds if either axis is out of bounds.
- Step cost stays 1.
- H becomes Chebyshev: max(|dx|,|dy|).
- Nb_Count can reach 8.
- When undefined, there are 4 directions, H is Manhattan, and Nb_Dir[2] is tied 0.

Test Plan:
1. No walls, Nb_Ready=1, Start with Cur=(5,5) G=3 Goal=(9,5) -> 4 beats, then Done with Nb_Count=4:
   - N (5,4) G=4 F=9
   - E (6,5) G=4 F=7
   - S (5,6) G=4 F=9
   - W (4,5) G=4 F=9
2. Cur=(0,0) -> no Wall_Rd for N or W; only E (1,0) and S (0,1) are emitted; Nb_Count=2.
3. Wall at (6,5), Cur=(5,5) -> a Wall_Rd is seen with Wall_Addr=0x56; the E beat is absent; Nb_Count=3.
4. Hold Nb_Ready=0 for 5 cycles on the E beat -> Nb_Valid stays 1, fields are stable, the beat is accepted exactly once, and no duplicate follows.
5. Cur_G=255 -> every beat has Nb_G=255 and Nb_F=255.
6. Assert Reset during EMIT -> Nb_Valid, Busy and Done go to 0 asynchronously; after release, a new Start expands normally.
